// File: rtl/mod_mul_pkg.sv
// Shared constants for the Kyber modular multiplier and a reference model of (x*y) mod q.
package mod_mul_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int DATA_WIDTH = 12;
  localparam int BARRETT_K  = 24;
  localparam int BARRETT_M  = 5039;

  // Exact reference using the '%' operator, independent of the Barrett datapath.
  function automatic logic [DATA_WIDTH-1:0] mod_mul_ref(input logic [DATA_WIDTH-1:0] x,
                                                        input logic [DATA_WIDTH-1:0] y);
    logic [31:0] prod;
    prod = 32'(x) * 32'(y);
    return DATA_WIDTH'(prod % 32'(KYBER_Q));
  endfunction

endpackage

// File: rtl/barrett_reduce.sv
// Barrett reduction of a 2W-bit product: stages S3..S5, fixed 3-cycle latency.
// Define MODMUL_DSP_HINT_EN to tag the S3 multiplier register for DSP mapping.
module barrett_reduce
  import mod_mul_pkg::*;
#(
  parameter int DATA_WIDTH = mod_mul_pkg::DATA_WIDTH,
  parameter int MODULUS    = KYBER_Q,
  parameter int BARRETT_K  = 2*DATA_WIDTH,
  parameter int BARRETT_M  = int'((64'd1 << BARRETT_K) / MODULUS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    valid_in,
  input  logic [2*DATA_WIDTH-1:0] p,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    valid_out
);

  localparam int P_W = 2*DATA_WIDTH;
  localparam int M_W = $clog2(BARRETT_M + 1);
  localparam int T_W = P_W + M_W;
  localparam int R_W = DATA_WIDTH + 2;

  localparam logic [M_W-1:0] M_C = M_W'(BARRETT_M);
  localparam logic [T_W-1:0] Q_T = T_W'(MODULUS);
  localparam logic [R_W-1:0] Q_R = R_W'(MODULUS);

  // Remainder may reach 3q-1 when both operands are >= q; two subtracts bring it below q.
  function automatic logic [DATA_WIDTH-1:0] cond_sub(input logic [R_W-1:0] r);
    logic [R_W-1:0] s;
    s = r;
    if (s >= Q_R) s = s - Q_R;
    if (s >= Q_R) s = s - Q_R;
    return s[DATA_WIDTH-1:0];
  endfunction

`ifdef MODMUL_DSP_HINT_EN
  (* use_dsp = "yes" *) logic [T_W-1:0] t_p3;
`else
  logic [T_W-1:0] t_p3;
`endif
  logic [P_W-1:0] p_p3;
  logic           vld_p3;
  logic [R_W-1:0] r_p4;
  logic           vld_p4;

  logic [T_W-1:0] qh;
  logic [T_W-1:0] qh_q;
  logic [R_W-1:0] r_next;

  // r only needs its low W+2 bits, so the subtraction is done modulo 2**(W+2).
  always_comb begin
    qh     = t_p3 >> BARRETT_K;
    qh_q   = qh * Q_T;
    r_next = R_W'(p_p3) - R_W'(qh_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_p3      <= '0;
      p_p3      <= '0;
      vld_p3    <= 1'b0;
      r_p4      <= '0;
      vld_p4    <= 1'b0;
      result    <= '0;
      valid_out <= 1'b0;
    end else if (enable) begin
      // S3: Barrett estimate product
      t_p3      <= T_W'(p) * T_W'(M_C);
      p_p3      <= p;
      vld_p3    <= valid_in;
      // S4: quotient estimate and partial remainder
      r_p4      <= r_next;
      vld_p4    <= vld_p3;
      // S5: final correction; bubbles leave result untouched
      valid_out <= vld_p4;
      if (vld_p4) result <= cond_sub(r_p4);
    end
  end

endmodule

// File: rtl/mod_multiplier_pipeline.sv
// Pipelined (a*b) mod q, 5-cycle latency: S1 operand register, S2 product, S3..S5 Barrett.
// Define MODMUL_DSP_HINT_EN to tag the S2 multiplier register for DSP mapping.
module mod_multiplier_pipeline
  import mod_mul_pkg::*;
#(
  parameter int DATA_WIDTH = mod_mul_pkg::DATA_WIDTH,
  parameter int MODULUS    = KYBER_Q,
  parameter int BARRETT_K  = 2*DATA_WIDTH,
  parameter int BARRETT_M  = int'((64'd1 << BARRETT_K) / MODULUS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  valid_out
);

  localparam int P_W = 2*DATA_WIDTH;

  logic [DATA_WIDTH-1:0] a_p1;
  logic [DATA_WIDTH-1:0] b_p1;
  logic                  vld_p1;
`ifdef MODMUL_DSP_HINT_EN
  (* use_dsp = "yes" *) logic [P_W-1:0] p_p2;
`else
  logic [P_W-1:0] p_p2;
`endif
  logic                  vld_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_p1   <= '0;
      b_p1   <= '0;
      vld_p1 <= 1'b0;
      p_p2   <= '0;
      vld_p2 <= 1'b0;
    end else if (enable) begin
      // S1: operand capture
      a_p1   <= a;
      b_p1   <= b;
      vld_p1 <= valid_in;
      // S2: full-width unsigned product
      p_p2   <= P_W'(a_p1) * P_W'(b_p1);
      vld_p2 <= vld_p1;
    end
  end

  barrett_reduce #(
    .DATA_WIDTH (DATA_WIDTH),
    .MODULUS    (MODULUS),
    .BARRETT_K  (BARRETT_K),
    .BARRETT_M  (BARRETT_M)
  ) u_reduce (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .valid_in  (vld_p2),
    .p         (p_p2),
    .result    (result),
    .valid_out (valid_out)
  );

endmodule

// File: tb/tb_mod_multiplier_pipeline.sv
// Directed and streaming bench for mod_multiplier_pipeline with a reference-model scoreboard.
module tb_mod_multiplier_pipeline;
  import mod_mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        valid_in;
  logic [11:0] a;
  logic [11:0] b;
  logic [11:0] result;
  logic        valid_out;

  int total = 0;
  int bad   = 0;

  logic [11:0] last_r;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[13];

  logic        pv[5];
  logic [11:0] pr[5];
  logic        ev;
  logic [11:0] er;
  int          issued;
  int          outs;

  mod_multiplier_pipeline dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .result    (result),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0b want=%0b", nm, got, exp);
    end
  endtask

  task automatic chk_val(input string nm, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid pulse, then watch the output for six enabled edges.
  task automatic run_single(input logic [11:0] va, input logic [11:0] vb,
                            input logic [11:0] ve, input string nm);
    enable   = 1'b1;
    valid_in = 1'b1;
    a        = va;
    b        = vb;
    for (int k = 1; k <= 6; k++) begin
      tick();
      valid_in = 1'b0;
      a        = 12'($urandom);
      b        = 12'($urandom);
      if (k == 5) begin
        chk_bit({nm, " valid@5"}, valid_out, 1'b1);
        chk_val({nm, " result"}, result, ve);
      end else begin
        chk_bit($sformatf("%s valid@%0d", nm, k), valid_out, 1'b0);
        chk_val($sformatf("%s hold@%0d", nm, k), result, (k == 6) ? ve : last_r);
      end
    end
    last_r = ve;
  endtask

  // One clock of the streaming run, with a 5-deep reference pipeline advancing on enable.
  task automatic step(input logic en, input logic vin, input logic [11:0] ra, input logic [11:0] rb);
    enable   = en;
    valid_in = vin;
    a        = ra;
    b        = rb;
    tick();
    if (en) begin
      if (vin) issued++;
      for (int k = 4; k > 0; k--) begin
        pv[k] = pv[k-1];
        pr[k] = pr[k-1];
      end
      pv[0] = vin;
      pr[0] = mod_mul_ref(ra, rb);
      ev = pv[4];
      if (pv[4]) begin
        er = pr[4];
        outs++;
      end
    end
    chk_bit("stream valid", valid_out, ev);
    chk_val("stream result", result, er);
  endtask

  initial begin
    vecs[0]  = '{12'd0,    12'd100,  12'd0,    "0*100"};
    vecs[1]  = '{12'd1,    12'd200,  12'd200,  "1*200"};
    vecs[2]  = '{12'd10,   12'd20,   12'd200,  "10*20"};
    vecs[3]  = '{12'd100,  12'd30,   12'd3000, "100*30"};
    vecs[4]  = '{12'd100,  12'd100,  12'd13,   "100*100"};
    vecs[5]  = '{12'd200,  12'd200,  12'd52,   "200*200"};
    vecs[6]  = '{12'd1000, 12'd5,    12'd1671, "1000*5"};
    vecs[7]  = '{12'd3328, 12'd2,    12'd3327, "3328*2"};
    vecs[8]  = '{12'd3328, 12'd3328, 12'd1,    "3328*3328"};
    vecs[9]  = '{12'd1664, 12'd2,    12'd3328, "1664*2"};
    vecs[10] = '{12'd3329, 12'd1,    12'd0,    "3329*1"};
    vecs[11] = '{12'd4095, 12'd4095, 12'd852,  "4095*4095"};
    vecs[12] = '{12'd3330, 12'd3330, 12'd1,    "3330*3330"};

    rst      = 1'b1;
    enable   = 1'b0;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    last_r   = '0;

    for (int k = 0; k < 3; k++) begin
      tick();
      chk_bit("reset valid_out", valid_out, 1'b0);
      chk_val("reset result", result, 12'd0);
    end
    rst    = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_bit("idle valid_out", valid_out, 1'b0);
      chk_val("idle result", result, 12'd0);
    end

    for (int i = 0; i < 13; i++)
      run_single(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    for (int k = 0; k < 5; k++) begin
      pv[k] = 1'b0;
      pr[k] = '0;
    end
    ev     = 1'b0;
    er     = last_r;
    issued = 0;
    outs   = 0;
    for (int cyc = 0; cyc < 5000 && issued < 1000; cyc++) begin
      if ($urandom_range(0, 3) != 0)
        step(1'b1, 1'b1, 12'($urandom), 12'($urandom));
      else
        step(1'b0, 1'($urandom), 12'($urandom), 12'($urandom));
    end
    for (int k = 0; k < 6; k++)
      step(1'b1, 1'b0, 12'($urandom), 12'($urandom));
    chk_int("stream issued", issued, 1000);
    chk_int("stream outputs", outs, 1000);
    last_r = er;

    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1;
      a        = 12'd100 + 12'(k);
      b        = 12'd77;
      tick();
    end
    valid_in = 1'b0;
    tick();
    rst    = 1'b1;
    enable = 1'b0;
    tick();
    chk_bit("midrst valid_out", valid_out, 1'b0);
    chk_val("midrst result", result, 12'd0);
    rst    = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_bit("post-reset no valid", valid_out, 1'b0);
      chk_val("post-reset result", result, 12'd0);
    end
    last_r = '0;
    run_single(12'd7, 12'd9, 12'd63, "post_rst 7*9");
    run_single(12'd2000, 12'd3000, mod_mul_ref(12'd2000, 12'd3000), "post_rst 2000*3000");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
